// File: rtl/dma_core_mc.sv
// dma_core_mc: multi-channel word-copy DMA, round-robin per word, AXI-Lite master.
// Define DMA_MC_IRQ_EN to add the irq/irq_ack completion interrupt.
module dma_core_mc #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_src_addr,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_dst_addr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]  ch_len,
  input  logic [NUM_CH-1:0]            ch_start,
  output logic [NUM_CH-1:0]            ch_busy,
  output logic [NUM_CH-1:0]            ch_done,
  output logic                         awvalid,
  output logic [ADDR_WIDTH-1:0]        awaddr,
  input  logic                         awready,
  output logic                         wvalid,
  output logic [DATA_WIDTH-1:0]        wdata,
  input  logic                         wready,
  input  logic                         bvalid,
  output logic                         bready,
  output logic                         arvalid,
  output logic [ADDR_WIDTH-1:0]        araddr,
  input  logic                         arready,
  input  logic                         rvalid,
  input  logic [DATA_WIDTH-1:0]        rdata,
  output logic                         rready
`ifdef DMA_MC_IRQ_EN
  ,
  input  logic [NUM_CH-1:0]            irq_ack,
  output logic                         irq
`endif
);

  localparam int SW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SW1 = SW + 1;

  typedef enum logic [2:0] {
    IDLE, ARB, RD_ADDR, RD_DATA, WR, WR_RESP, UPDATE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] src_q [NUM_CH];
  logic [ADDR_WIDTH-1:0] src_d [NUM_CH];
  logic [ADDR_WIDTH-1:0] dst_q [NUM_CH];
  logic [ADDR_WIDTH-1:0] dst_d [NUM_CH];
  logic [LEN_WIDTH-1:0]  rem_q [NUM_CH];
  logic [LEN_WIDTH-1:0]  rem_d [NUM_CH];

  logic [NUM_CH-1:0] busy_q, busy_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [SW-1:0]     rrp_q, rrp_d;

  logic                  arv_q, arv_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  rrdy_q, rrdy_d;
  logic                  awv_q, awv_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  wv_q, wv_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  brdy_q, brdy_d;

  logic [NUM_CH-1:0] rot;
  logic [SW:0]       cand;
  logic [SW-1:0]     pick;
  logic              found;
  logic              last;
  logic [NUM_CH-1:0] fin_mask;

  // Round-robin pick: first busy channel at or after rrp_q, wrapping.
  always_comb begin
    rot   = NUM_CH'({busy_q, busy_q} >> rrp_q);
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        cand = {1'b0, rrp_q} + SW1'(k);
        if (cand >= SW1'(NUM_CH)) cand = cand - SW1'(NUM_CH);
        pick  = cand[SW-1:0];
        found = 1'b1;
      end
    end
  end

  // Channel bookkeeping, FSM next state and next values of registered outputs.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    busy_d   = busy_q;
    done_d   = done_q;
    sel_d    = sel_q;
    rrp_d    = rrp_q;
    araddr_d = araddr_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    awv_d    = awv_q;
    wv_d     = wv_q;
    last     = (rem_q[sel_q] == LEN_WIDTH'(1));
    fin_mask = last ? (NUM_CH'(1) << sel_q) : '0;

    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_start[i] && !busy_q[i]) begin
        if (ch_len[i*LEN_WIDTH +: LEN_WIDTH] == '0) begin
          done_d[i] = 1'b1;
        end else begin
          src_d[i]  = ch_src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          dst_d[i]  = ch_dst_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          rem_d[i]  = ch_len[i*LEN_WIDTH +: LEN_WIDTH];
          busy_d[i] = 1'b1;
          done_d[i] = 1'b0;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (|busy_q) state_d = ARB;
      end
      ARB: begin
        if (found) begin
          sel_d    = pick;
          araddr_d = src_q[pick];
          state_d  = RD_ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rvalid) begin
          wdata_d  = rdata;
          awaddr_d = dst_q[sel_q];
          awv_d    = 1'b1;
          wv_d     = 1'b1;
          state_d  = WR;
        end
      end
      WR: begin
        awv_d = awv_q & ~awready;
        wv_d  = wv_q & ~wready;
        if ((!awv_q || awready) && (!wv_q || wready)) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid) state_d = UPDATE;
      end
      UPDATE: begin
        src_d[sel_q] = src_q[sel_q] + 1'b1;
        dst_d[sel_q] = dst_q[sel_q] + 1'b1;
        rem_d[sel_q] = rem_q[sel_q] - 1'b1;
        rrp_d = (sel_q == SW'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;
        if (last) begin
          busy_d[sel_q] = 1'b0;
          done_d[sel_q] = 1'b1;
        end
        state_d = (|(busy_q & ~fin_mask)) ? ARB : IDLE;
      end
      default: state_d = IDLE;
    endcase

    arv_d  = (state_d == RD_ADDR);
    rrdy_d = (state_d == RD_DATA);
    brdy_d = (state_d == WR_RESP);
  end

  // State, channel and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= '0;
      done_q   <= '0;
      sel_q    <= '0;
      rrp_q    <= '0;
      arv_q    <= 1'b0;
      araddr_q <= '0;
      rrdy_q   <= 1'b0;
      awv_q    <= 1'b0;
      awaddr_q <= '0;
      wv_q     <= 1'b0;
      wdata_q  <= '0;
      brdy_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
        rem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sel_q    <= sel_d;
      rrp_q    <= rrp_d;
      arv_q    <= arv_d;
      araddr_q <= araddr_d;
      rrdy_q   <= rrdy_d;
      awv_q    <= awv_d;
      awaddr_q <= awaddr_d;
      wv_q     <= wv_d;
      wdata_q  <= wdata_d;
      brdy_q   <= brdy_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rem_q    <= rem_d;
    end
  end

  assign ch_busy = busy_q;
  assign ch_done = done_q;
  assign arvalid = arv_q;
  assign araddr  = araddr_q;
  assign rready  = rrdy_q;
  assign awvalid = awv_q;
  assign awaddr  = awaddr_q;
  assign wvalid  = wv_q;
  assign wdata   = wdata_q;
  assign bready  = brdy_q;

`ifdef DMA_MC_IRQ_EN
  logic [NUM_CH-1:0] irq_pend_q, irq_pend_d;
  logic              irq_q;

  // Pending bit set on done rising edge; set beats a same-cycle ack.
  always_comb begin
    irq_pend_d = (irq_pend_q & ~irq_ack) | (done_d & ~done_q);
  end

  // Pending flags and the registered interrupt line.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_pend_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_pend_q <= irq_pend_d;
      irq_q      <= |irq_pend_q;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_dma_core_mc.sv
// tb_dma_core_mc: directed tests with scoreboard queues for AXI reads/writes.
// Memory slave model, negedge monitor pops expected addresses and write data.
module tb_dma_core_mc;

  localparam int NCH = 2;

  logic          clk;
  logic          rst;
  logic [63:0]   ch_src_addr;
  logic [63:0]   ch_dst_addr;
  logic [31:0]   ch_len;
  logic [1:0]    ch_start;
  logic [1:0]    ch_busy;
  logic [1:0]    ch_done;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   awaddr, wdata, araddr, rdata;
`ifdef DMA_MC_IRQ_EN
  logic [1:0]    irq_ack;
  logic          irq;
`endif

  dma_core_mc #(
    .NUM_CH(NCH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_src_addr(ch_src_addr), .ch_dst_addr(ch_dst_addr),
    .ch_len(ch_len), .ch_start(ch_start),
    .ch_busy(ch_busy), .ch_done(ch_done),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rready(rready)
`ifdef DMA_MC_IRQ_EN
    , .irq_ack(irq_ack), .irq(irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // memory slave model
  logic [31:0] mem [0:255];
  logic        stall, bp;
  logic        aw_got, w_got;
  logic [31:0] aw_a, w_v;
  int          hold;
  int          wr_count;
  logic        ar_evt, wr_evt;
  logic [31:0] ar_evt_addr, wr_evt_addr, wr_evt_data;
  logic        aw_f, w_f, ha, hw;
  logic [31:0] ta, td;

  assign arready = 1'b1;
  assign wready  = !stall;
  assign awready = !stall && (!bp || (w_got && hold == 0));

  always @(posedge clk) begin
    ar_evt <= 1'b0;
    wr_evt <= 1'b0;
    if (rst) begin
      rvalid <= 1'b0;
      bvalid <= 1'b0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      hold   <= 0;
    end else begin
      if (hold != 0) hold <= hold - 1;
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid      <= 1'b1;
        rdata       <= mem[araddr[7:0]];
        ar_evt      <= 1'b1;
        ar_evt_addr <= araddr;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      if (aw_f) aw_a <= awaddr;
      if (w_f) begin
        w_v <= wdata;
        if (bp) hold <= 3;
      end
      ha = aw_got || aw_f;
      hw = w_got || w_f;
      if (ha && hw) begin
        ta = aw_f ? awaddr : aw_a;
        td = w_f ? wdata : w_v;
        mem[ta[7:0]] <= td;
        wr_evt       <= 1'b1;
        wr_evt_addr  <= ta;
        wr_evt_data  <= td;
        bvalid       <= 1'b1;
        aw_got       <= 1'b0;
        w_got        <= 1'b0;
        wr_count++;
      end else begin
        aw_got <= ha;
        w_got  <= hw;
      end
    end
  end

  // scoreboard
  logic [31:0] exp_ar [$];
  logic [31:0] exp_wa [$];
  logic [31:0] exp_wd [$];

  always @(negedge clk) begin
    if (ar_evt) begin
      if (exp_ar.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ar_unexpected: actual=%0h required=none", ar_evt_addr);
      end else begin
        chk("araddr_seq", ar_evt_addr, exp_ar.pop_front());
      end
    end
    if (wr_evt) begin
      if (exp_wa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: actual=%0h required=none", wr_evt_addr);
      end else begin
        chk("wr_addr", wr_evt_addr, exp_wa.pop_front());
        chk("wr_data", wr_evt_data, exp_wd.pop_front());
      end
    end
    if (w_got) begin
      chk("bp_wvalid_drop", wvalid, 0);
      chk("bp_awvalid_hold", awvalid, 1);
    end
    if (aw_got || w_got || bvalid) chk("rd_waits_b", arvalid, 0);
  end

  task automatic set_ch(input int ch, input logic [31:0] s,
                        input logic [31:0] d, input logic [15:0] l);
    ch_src_addr[ch*32 +: 32] = s;
    ch_dst_addr[ch*32 +: 32] = d;
    ch_len[ch*16 +: 16]      = l;
  endtask

  task automatic pulse(input logic [1:0] m);
    @(negedge clk);
    ch_start = m;
    @(posedge clk);
    #1;
    ch_start = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input logic [1:0] m, input int maxc, output int c);
    c = 0;
    while (((ch_done & m) != m) && c < maxc) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_wa.push_back(a);
    exp_wd.push_back(d);
  endtask

  int  c;
  logic seen;

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    bp = 1'b0;
    ch_src_addr = '0;
    ch_dst_addr = '0;
    ch_len = '0;
    ch_start = '0;
    wr_count = 0;
`ifdef DMA_MC_IRQ_EN
    irq_ack = '0;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'hDDDD_DDDA; mem[5] = 32'hDDDD_DDDB;
    mem[6] = 32'hDDDD_DDDC; mem[7] = 32'hDDDD_DDDD;
    mem[8] = 32'h0808_0808;
    mem[0] = 32'h1000_0000; mem[1] = 32'h1000_0001; mem[2] = 32'h1000_0002;
    mem[50] = 32'h5000_0050; mem[51] = 32'h5000_0051;
    mem[20] = 32'h2020_2020; mem[21] = 32'h2121_2121;
    mem[40] = 32'h4040_0040; mem[41] = 32'h4040_0041; mem[42] = 32'h4040_0042;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
    chk("rst_addrs", {araddr, awaddr}, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy_done", {ch_busy, ch_done}, 0);
    chk("rst_state", dut.state_q, 0);
    chk("rst_rrptr", dut.rrp_q, 0);
    @(negedge clk);
    rst = 1'b0;

    // single channel copy, latency 6N+1
    set_ch(0, 4, 10, 4);
    for (int i = 0; i < 4; i++) exp_ar.push_back(32'(4 + i));
    push_wr(10, 32'hDDDD_DDDA);
    push_wr(11, 32'hDDDD_DDDB);
    push_wr(12, 32'hDDDD_DDDC);
    push_wr(13, 32'hDDDD_DDDD);
    pulse(2'b01);
    chk("t1_busy_rise", ch_busy, 2'b01);
    wait_done(2'b01, 100, c);
    chk("t1_latency", c, 25);
    chk("t1_busy_fall", ch_busy, 0);
    chk("t1_mem10", mem[10], 32'hDDDD_DDDA);
    chk("t1_mem13", mem[13], 32'hDDDD_DDDD);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_queues", exp_ar.size() + exp_wa.size(), 0);

    // interleave two channels
    do_reset();
    set_ch(0, 0, 100, 3);
    set_ch(1, 50, 150, 2);
    exp_ar.push_back(0);
    exp_ar.push_back(50);
    exp_ar.push_back(1);
    exp_ar.push_back(51);
    exp_ar.push_back(2);
    push_wr(100, 32'h1000_0000);
    push_wr(150, 32'h5000_0050);
    push_wr(101, 32'h1000_0001);
    push_wr(151, 32'h5000_0051);
    push_wr(102, 32'h1000_0002);
    pulse(2'b11);
    wait_done(2'b11, 200, c);
    chk("t2_done", ch_done, 2'b11);
    chk("t2_busy", ch_busy, 0);
    chk("t2_mem102", mem[102], 32'h1000_0002);
    chk("t2_mem151", mem[151], 32'h5000_0051);
    chk("t2_queues", exp_ar.size() + exp_wa.size(), 0);

    // zero-length job
    do_reset();
    set_ch(1, 60, 160, 0);
    pulse(2'b10);
    chk("t3_done_next", ch_done, 2'b10);
    chk("t3_busy_low", ch_busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (arvalid || awvalid || ch_busy[1]) seen = 1'b1;
    end
    chk("t3_no_traffic", seen, 0);

    // write backpressure on awready
    do_reset();
    bp = 1'b1;
    wr_count = 0;
    set_ch(0, 20, 30, 2);
    exp_ar.push_back(20);
    exp_ar.push_back(21);
    push_wr(30, 32'h2020_2020);
    push_wr(31, 32'h2121_2121);
    pulse(2'b01);
    wait_done(2'b01, 200, c);
    chk("t4_done", ch_done, 2'b01);
    chk("t4_wr_once", wr_count, 2);
    chk("t4_mem31", mem[31], 32'h2121_2121);
    chk("t4_queues", exp_ar.size() + exp_wa.size(), 0);
    bp = 1'b0;

    // start while busy is ignored
    do_reset();
    set_ch(0, 40, 60, 3);
    exp_ar.push_back(40);
    exp_ar.push_back(41);
    exp_ar.push_back(42);
    push_wr(60, 32'h4040_0040);
    push_wr(61, 32'h4040_0041);
    push_wr(62, 32'h4040_0042);
    pulse(2'b01);
    repeat (8) @(posedge clk);
    set_ch(0, 90, 200, 5);
    pulse(2'b01);
    wait_done(2'b01, 200, c);
    chk("t5_done", ch_done, 2'b01);
    chk("t5_mem62", mem[62], 32'h4040_0042);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_queues", exp_ar.size() + exp_wa.size(), 0);

    // reset in the middle of WR
    stall = 1'b1;
    set_ch(1, 5, 70, 1);
    exp_ar.push_back(5);
    pulse(2'b10);
    c = 0;
    while (!awvalid && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("t6_reach_wr", awvalid, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_valids", {arvalid, awvalid, wvalid, bready, rready}, 0);
    chk("t6_rst_busy_done", {ch_busy, ch_done}, 0);
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    set_ch(0, 8, 80, 1);
    exp_ar.push_back(8);
    push_wr(80, 32'h0808_0808);
    pulse(2'b01);
    wait_done(2'b01, 100, c);
    chk("t6_fresh_latency", c, 7);
    chk("t6_mem80", mem[80], 32'h0808_0808);
    chk("t6_queues", exp_ar.size() + exp_wa.size(), 0);

`ifdef DMA_MC_IRQ_EN
    do_reset();
    set_ch(1, 0, 0, 0);
    pulse(2'b10);
    chk("irq_not_yet", irq, 0);
    @(posedge clk);
    #1;
    chk("irq_rise", irq, 1);
    set_ch(0, 0, 0, 0);
    @(negedge clk);
    ch_start = 2'b01;
    irq_ack  = 2'b10;
    @(posedge clk);
    #1;
    ch_start = '0;
    irq_ack  = '0;
    chk("irq_pend", dut.irq_pend_q, 2'b01);
    @(posedge clk);
    #1;
    chk("irq_hold", irq, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
